bus_slot_arbiter: RTL and testbench
===================================

Name: bus_slot_arbiter

Overview:
- Round-robin arbiter sharing the single serial bus (`bus_out`) among the 16 node transmitters of the FPGA top.
- Grants the bus to one node per frame and times the frame bit by bit. The granted node's serializer uses `bit_idx` to pick the bit it drives.
- Inserts a configurable inter-frame gap and rotates priority so every requesting node is served within 16 frames.

Parameters:
- NODES, 16, number of requesters (fixed at 16; `grant_idx` is 4 bits)
- FRAME_BITS, 78, bus cycles per frame: src addr 4 + dst addr 4 + mod 2 + data 64 + CRC 4
- GAP_CYCLES, 2, idle bus cycles forced after each frame (0 allowed)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  16  bit i high = node i has a frame pending; level, held until served
- grant  out  16  one-hot grant; all zero when no frame is in progress
- grant_idx  out  4  binary index of the granted node; 0 when idle
- bus_busy  out  1  high while a frame is in progress (state XMIT)
- bit_idx  out  7  frame bit counter, 0..FRAME_BITS-1; 0 outside XMIT
- frame_start  out  1  one-cycle pulse on the first XMIT cycle
- frame_done  out  1  one-cycle pulse on the last XMIT cycle (bit_idx = FRAME_BITS-1)

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, `rr_ptr` = 0.
  - grant = 0, grant_idx = 0, bus_busy = 0, bit_idx = 0, frame_start = 0, frame_done = 0.
  - Reset asserted mid-frame aborts the frame immediately; outputs clear without waiting for a clock edge.
- States: IDLE, XMIT, GAP.
- IDLE:
  - Each cycle, search `req` starting at `rr_ptr`, ascending, wrapping 15 -> 0. The first set bit is the winner w.
  - If any `req` bit is set: next state XMIT, grant = 1<<w, grant_idx = w, bit_idx = 0, frame_start = 1 in that XMIT cycle, `rr_ptr` <= (w+1) mod 16.
  - If `req` = 0: stay in IDLE; `rr_ptr` unchanged.
  - Latency: req seen at edge N -> grant visible after edge N+1.
- XMIT:
  - bit_idx increments by 1 each cycle.
  - grant and grant_idx are frozen for the whole frame.
  - `req` changes, including the granted node dropping `req`, are ignored until the frame completes. A frame always runs all FRAME_BITS cycles.
  - Cycle with bit_idx = FRAME_BITS-1: frame_done = 1. Next state is GAP if GAP_CYCLES > 0, else IDLE.
- GAP:
  - grant = 0, bus_busy = 0, bit_idx = 0.
  - Internal counter runs GAP_CYCLES cycles, then IDLE.
  - `req` is not sampled in GAP.
- Minimum spacing between back-to-back frames is GAP_CYCLES + 1 idle cycles (the +1 is the IDLE arbitration cycle).
- Simultaneous requests: the lowest index at or above `rr_ptr` (with wrap) wins. A node that just transmitted has the lowest priority next round.
- frame_start and frame_done are never high together (FRAME_BITS ≥ 2 required).
- bit_idx width is $clog2(FRAME_BITS). At the default, bits 6:0; never exceeds FRAME_BITS-1 and never wraps inside a frame.
- Outputs are registered; no combinational path from `req` to `grant`.

Optional Feature:
- Macro: BUS_SLOT_ARB_PRIO0_EN.
- Defined: node 0 is an urgent/management node.
  - In IDLE, if req[0] = 1, node 0 wins regardless of `rr_ptr`.
  - `rr_ptr` is not updated on a node-0 grant, so the rotation among nodes 1..15 is preserved.
- Undefined: node 0 takes part in plain round-robin like every other node.

Test Plan:
- Single requester: reset, req = 16'h0002 held.
  - Expect grant = 16'h0002 and grant_idx = 1 one cycle after the first sampling edge.
  - Expect frame_start on bit_idx 0 and frame_done on bit_idx 77.
  - Then 2 GAP cycles with grant = 0, 1 IDLE cycle, then the next frame to node 1.
- Rotation: req = 16'hFFFF held.
  - Expect grant order 0, 1, 2, …, 15, 0; each frame is 78 cycles and frames are 3 cycles apart.
- Wrap: rr_ptr = 14 (after serving node 13), req = 16'h0009.
  - Expect node 0 granted, then node 3, then node 0.
- Drop mid-frame: grant to node 5, deassert req[5] at bit_idx 30.
  - Expect grant held through bit_idx 77 and frame_done asserted, then IDLE with no re-grant.
- Async reset: assert reset_n = 0 at bit_idx 40, between clock edges.
  - Expect grant, bus_busy and bit_idx at 0 immediately.
  - After release with req = 16'h0010, expect node 4 granted (rr_ptr back to 0).
- BUS_SLOT_ARB_PRIO0_EN: req = 16'h0101 held.
  - Expect node 0 granted on every frame and node 8 never granted.
  - Drop req[0]: node 8 is granted next.
  - Without the macro: order alternates 0, 8, 0, 8.

Source files
------------

// File: rtl/bus_slot_arbiter_if.sv
// Handshake bundle between the slot arbiter and the 16 node serializers.
// slave = arbiter side, master = node/requester side.
interface bus_slot_arbiter_if #(
    parameter int NODES = 16,
    parameter int IDX_W = 7
);
    logic [NODES-1:0] req;
    logic [NODES-1:0] grant;
    logic [3:0]       grant_idx;
    logic             bus_busy;
    logic [IDX_W-1:0] bit_idx;
    logic             frame_start;
    logic             frame_done;

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output bus_busy,
        output bit_idx,
        output frame_start,
        output frame_done
    );

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  bus_busy,
        input  bit_idx,
        input  frame_start,
        input  frame_done
    );
endinterface

// File: rtl/bus_slot_arbiter.sv
// Round-robin frame-slot arbiter for the shared serial bus, with frame bit timing.
// Optional BUS_SLOT_ARB_PRIO0_EN: node 0 always wins and does not move the rotation.
module bus_slot_arbiter #(
    parameter int NODES      = 16,
    parameter int FRAME_BITS = 78,
    parameter int GAP_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    bus_slot_arbiter_if.slave bus
);
    localparam int IDX_W    = $clog2(FRAME_BITS);
    localparam int PTR_W    = $clog2(NODES);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(FRAME_BITS - 1);
    localparam logic [NODES-1:0] ONE_HOT0 = NODES'(1);

    typedef enum logic [1:0] {
        IDLE,
        XMIT,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NODES-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] grant_idx_q, grant_idx_d;
    logic             bus_busy_q, bus_busy_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic             ptr_adv;

    // Search starts at rr_ptr and wraps; the first requester found wins.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        cand    = '0;
        ptr_adv = 1'b1;
        for (int k = 0; k < NODES; k++) begin
            cand = rr_ptr_q + PTR_W'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
`ifdef BUS_SLOT_ARB_PRIO0_EN
        if (bus.req[0]) begin
            found   = 1'b1;
            win     = '0;
            ptr_adv = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        bus_busy_d    = bus_busy_q;
        bit_idx_d     = bit_idx_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        gap_cnt_d     = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = XMIT;
                    grant_d       = ONE_HOT0 << win;
                    grant_idx_d   = win;
                    bus_busy_d    = 1'b1;
                    bit_idx_d     = '0;
                    frame_start_d = 1'b1;
                    if (ptr_adv) rr_ptr_d = win + PTR_W'(1);
                end
            end
            XMIT: begin
                if (bit_idx_q == LAST_BIT) begin
                    grant_d     = '0;
                    grant_idx_d = '0;
                    bus_busy_d  = 1'b0;
                    bit_idx_d   = '0;
                    gap_cnt_d   = '0;
                    state_d     = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    bit_idx_d    = bit_idx_q + IDX_W'(1);
                    frame_done_d = (bit_idx_q == LAST_BIT - IDX_W'(1));
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = IDLE;
                else gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            bus_busy_q    <= 1'b0;
            bit_idx_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            bus_busy_q    <= bus_busy_d;
            bit_idx_q     <= bit_idx_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = 4'(grant_idx_q);
    assign bus.bus_busy    = bus_busy_q;
    assign bus.bit_idx     = bit_idx_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Scoreboard bench for bus_slot_arbiter: expected winners queued from a
// reference round-robin model, popped as each frame appears on the bus.
module tb_bus_slot_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_ptr = 0;
    int   exp_q[$];

    bus_slot_arbiter_if #(.NODES(16), .IDX_W(7)) bus_if ();

    bus_slot_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clock = ~clock;

    function automatic int model_pick(logic [15:0] r);
`ifdef BUS_SLOT_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (model_ptr + k) % 16;
            if (r[idx]) begin
                model_ptr = (idx + 1) % 16;
                return idx;
            end
        end
        return -1;
    endfunction

    task automatic apply_reset();
        bus_if.req = '0;
        reset_n = 1'b0;
        model_ptr = 0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Follows one frame: idle cycles before it, then every XMIT cycle to frame_done.
    task automatic run_frame(input int drop_at, output int idx, output int len,
                             output int idle_n, output bit clean, output bit ok);
        logic [15:0] g0;
        idle_n = 0; clean = 1'b1; ok = 1'b1; idx = -1; len = 0;
        @(negedge clock);
        while (!bus_if.frame_start && idle_n < 300) begin
            if (bus_if.grant !== '0 || bus_if.bit_idx !== '0 ||
                bus_if.bus_busy !== 1'b0 || bus_if.frame_done !== 1'b0)
                clean = 1'b0;
            idle_n++;
            @(negedge clock);
        end
        if (!bus_if.frame_start) begin
            ok = 1'b0;
            return;
        end
        idx = int'(bus_if.grant_idx);
        g0  = bus_if.grant;
        len = 1;
        if (g0 !== (16'h1 << idx) || bus_if.bit_idx !== 7'd0 ||
            bus_if.bus_busy !== 1'b1 || bus_if.frame_done !== 1'b0)
            clean = 1'b0;
        while (!bus_if.frame_done && len < 300) begin
            if (int'(bus_if.bit_idx) == drop_at) bus_if.req = '0;
            @(negedge clock);
            len++;
            if (bus_if.grant !== g0 || int'(bus_if.grant_idx) != idx ||
                bus_if.bit_idx !== 7'(len - 1) || bus_if.bus_busy !== 1'b1 ||
                bus_if.frame_start !== 1'b0)
                clean = 1'b0;
        end
        if (!bus_if.frame_done) ok = 1'b0;
    endtask

    task automatic check_frames(input string tag, input int nfr, input bit chk_first_idle);
        int idx, len, idle_n, exp;
        bit clean, ok;
        for (int f = 0; f < nfr; f++) begin
            run_frame(-1, idx, len, idle_n, clean, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s frame %0d timeout: got no complete frame, need one", tag, f);
                return;
            end
            n_cmp++;
            if (idx != exp) begin
                n_bad++;
                $display("FAIL %s frame %0d winner: got %0d need %0d", tag, f, idx, exp);
            end
            n_cmp++;
            if (len != 78 || !clean) begin
                n_bad++;
                $display("FAIL %s frame %0d shape: len %0d clean %0d need 78/1", tag, f, len, clean);
            end
            if (f > 0 || chk_first_idle) begin
                n_cmp++;
                if (idle_n != ((f == 0) ? 0 : 3)) begin
                    n_bad++;
                    $display("FAIL %s frame %0d spacing: got %0d need %0d", tag, f, idle_n,
                             (f == 0) ? 0 : 3);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus_if.req = '0;
        reset_n = 1'b0;
        #13;
        n_cmp++;
        if ({bus_if.grant, bus_if.grant_idx, bus_if.bus_busy, bus_if.bit_idx,
             bus_if.frame_start, bus_if.frame_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: grant %h idx %0d busy %0d bit %0d need all 0",
                     bus_if.grant, bus_if.grant_idx, bus_if.bus_busy, bus_if.bit_idx);
        end
        apply_reset();
        n_cmp++;
        if (bus_if.grant !== '0 || bus_if.bus_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: grant %h busy %0d need 0/0",
                     bus_if.grant, bus_if.bus_busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus_if.req = 16'h0002;
        repeat (2) exp_q.push_back(model_pick(bus_if.req));
        check_frames("single", 2, 1'b1);
        bus_if.req = '0;
    endtask

    task automatic test_rotation();
        apply_reset();
        bus_if.req = 16'hFFFF;
        repeat (17) exp_q.push_back(model_pick(bus_if.req));
        check_frames("rotation", 17, 1'b1);
        bus_if.req = '0;
    endtask

    task automatic test_wrap();
        apply_reset();
        bus_if.req = 16'h2000;
        exp_q.push_back(model_pick(bus_if.req));
        check_frames("wrap_setup", 1, 1'b1);
        bus_if.req = 16'h0009;
        repeat (3) exp_q.push_back(model_pick(bus_if.req));
        check_frames("wrap", 3, 1'b0);
        bus_if.req = '0;
    endtask

    task automatic test_drop_mid_frame();
        int idx, len, idle_n, busy_seen;
        bit clean, ok;
        apply_reset();
        bus_if.req = 16'h0020;
        exp_q.push_back(model_pick(bus_if.req));
        run_frame(30, idx, len, idle_n, clean, ok);
        n_cmp++;
        if (!ok || idx != exp_q.pop_front() || len != 78 || !clean) begin
            n_bad++;
            $display("FAIL drop_frame: ok %0d idx %0d len %0d clean %0d need 1/5/78/1",
                     ok, idx, len, clean);
        end
        busy_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus_if.bus_busy !== 1'b0 || bus_if.grant !== '0) busy_seen++;
        end
        n_cmp++;
        if (busy_seen != 0) begin
            n_bad++;
            $display("FAIL drop_regrant: got %0d busy cycles need 0", busy_seen);
        end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        bus_if.req = 16'h0004;
        n = 0;
        @(negedge clock);
        while (!(bus_if.bus_busy === 1'b1 && bus_if.bit_idx == 7'd40) && n < 300) begin
            n++;
            @(negedge clock);
        end
        n_cmp++;
        if (n >= 300) begin
            n_bad++;
            $display("FAIL async_setup: got no bit_idx 40 need one");
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.grant !== '0 || bus_if.bus_busy !== 1'b0 || bus_if.bit_idx !== '0 ||
            bus_if.grant_idx !== '0 || bus_if.frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clear: grant %h busy %0d bit %0d need 0/0/0",
                     bus_if.grant, bus_if.bus_busy, bus_if.bit_idx);
        end
        bus_if.req = 16'h0010;
        model_ptr = 0;
        exp_q.delete();
        @(negedge clock);
        #3 reset_n = 1'b1;
        exp_q.push_back(model_pick(bus_if.req));
        check_frames("async_release", 1, 1'b0);
        bus_if.req = '0;
    endtask

    task automatic test_prio0();
        apply_reset();
        bus_if.req = 16'h0101;
        repeat (4) exp_q.push_back(model_pick(bus_if.req));
        check_frames("prio_pair", 4, 1'b1);
        bus_if.req = 16'h0100;
        exp_q.push_back(model_pick(bus_if.req));
        check_frames("prio_drop0", 1, 1'b0);
        bus_if.req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_drop_mid_frame();
        test_async_reset();
        test_prio0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
